// File: rtl/aes_round_sequencer.sv
// Round / key-schedule sequencer for the masked AES-128/256 datapath.
// Optional synchronous abort port is enabled by defining AES_SEQ_ABORT_EN.
module aes_round_sequencer #(
   parameter int SBOX_LATENCY = 5,
   parameter int CNT_W = $clog2(SBOX_LATENCY)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       key_256,
   output logic       busy,
   output logic       key_en,
   output logic [1:0] ks_mode,
   output logic [7:0] rcon,
   output logic [3:0] round,
   output logic       final_round,
   output logic       done
`ifdef AES_SEQ_ABORT_EN
   ,
   input  logic       abort
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   localparam logic [1:0] KS_PASS = 2'b00;
   localparam logic [1:0] KS_RSR  = 2'b01;
   localparam logic [1:0] KS_SUB  = 2'b10;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SBOX_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_KEY  = CNT_W'(SBOX_LATENCY - 2);

   state_e           state_q, state_d;
   logic             mode_q, mode_d;
   logic [3:0]       round_q, round_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       rcon_q, rcon_d;
   logic [1:0]       ks_q, ks_d;
   logic             ken_q, ken_d;

   logic       abort_w;
   logic       accept;
   logic [1:0] start_mode;
   logic [3:0] nr_q, nr_d;

`ifdef AES_SEQ_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign accept     = (state_q == S_IDLE) && start && !abort_w;
   assign start_mode = key_256 ? KS_PASS : KS_RSR;
   assign nr_q       = mode_q ? 4'd14 : 4'd10;
   assign nr_d       = mode_d ? 4'd14 : 4'd10;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
   endfunction

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      round_d = round_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_RUN;
               mode_d  = key_256;
               round_d = 4'd1;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (abort_w) begin
               state_d = S_IDLE;
               round_d = 4'd0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (round_q == nr_q) begin
                  state_d = S_DONE;
               end else begin
                  round_d = round_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            round_d = 4'd0;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            round_d = 4'd0;
            cnt_d   = '0;
         end
      endcase
   end

   // Next-cycle key pulse: key r+1 is built in round r at cnt=L-2
   always_comb begin
      ken_d = (state_d == S_RUN) && (cnt_d == CNT_KEY) &&
              (round_d != nr_d);
      ks_d  = ks_q;
      if (accept) begin
         ks_d = start_mode;
      end
      if (ken_d) begin
         ks_d = (mode_d && !round_d[0]) ? KS_SUB : KS_RSR;
      end
      if (state_d == S_IDLE) begin
         ks_d = KS_PASS;
      end
   end

   always_comb begin
      rcon_d = rcon_q;
      if (state_d == S_IDLE) begin
         rcon_d = 8'h01;
      end else if (key_en && (ks_mode == KS_RSR)) begin
         rcon_d = xtime(rcon_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         round_q <= 4'd0;
         cnt_q   <= '0;
         rcon_q  <= 8'h01;
         ks_q    <= KS_PASS;
         ken_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         round_q <= round_d;
         cnt_q   <= cnt_d;
         rcon_q  <= rcon_d;
         ks_q    <= ks_d;
         ken_q   <= ken_d;
      end
   end

   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign round       = round_q;
   assign rcon        = rcon_q;
   assign final_round = busy && (round_q == nr_q);
   assign key_en      = accept || ken_q;
   assign ks_mode     = accept ? start_mode : ks_q;

endmodule
